// File: rtl/fx_pcs_pkg.sv
// fx_pcs_pkg: shared definitions for the 100BASE-FX PCS transmit path.
//   - 4B/5B control code groups (idle, stream delimiters, error)
//   - transmit FSM state encoding
//   - enc4b5b(): data nibble to 5-bit code group
package fx_pcs_pkg;

  localparam logic [4:0] CODE_I = 5'b11111;
  localparam logic [4:0] CODE_J = 5'b11000;
  localparam logic [4:0] CODE_K = 5'b10001;
  localparam logic [4:0] CODE_T = 5'b01101;
  localparam logic [4:0] CODE_R = 5'b00111;
  localparam logic [4:0] CODE_H = 5'b00100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SSD_K = 3'd1,
    S_DATA  = 3'd2,
    S_ESD_T = 3'd3,
    S_ESD_R = 3'd4
  } state_t;

  function automatic logic [4:0] enc4b5b(input logic [3:0] nibble);
    logic [4:0] code;
    case (nibble)
      4'h0:    code = 5'b11110;
      4'h1:    code = 5'b01001;
      4'h2:    code = 5'b10100;
      4'h3:    code = 5'b10101;
      4'h4:    code = 5'b01010;
      4'h5:    code = 5'b01011;
      4'h6:    code = 5'b01110;
      4'h7:    code = 5'b01111;
      4'h8:    code = 5'b10010;
      4'h9:    code = 5'b10011;
      4'hA:    code = 5'b10110;
      4'hB:    code = 5'b10111;
      4'hC:    code = 5'b11010;
      4'hD:    code = 5'b11011;
      4'hE:    code = 5'b11100;
      default: code = 5'b11101;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fx_nrzi_word.sv
// fx_nrzi_word: 5-bit parallel NRZI encoder with a stored line level.
//   i_clk, i_res : clock, synchronous active-high reset
//   code         : code group, bit 4 transmitted first
//   sym          : registered line symbol word, bit 4 transmitted first
// With NRZI_EN=0 the word is a registered copy of code and the level is unused.
module fx_nrzi_word #(
  parameter bit   NRZI_EN   = 1'b1,
  parameter logic NRZI_INIT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic [4:0] code,
  output logic [4:0] sym
);

  logic       level;
  logic [4:0] ripple;

  // Each output bit is the line level after that bit: a 1 toggles, a 0 holds.
  always_comb begin
    logic lv;
    ripple = '0;
    lv     = level;
    for (int i = 4; i >= 0; i--) begin
      lv        = lv ^ code[i];
      ripple[i] = lv;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      level <= NRZI_INIT;
      sym   <= 5'b00000;
    end else if (NRZI_EN) begin
      sym   <= ripple;
      level <= ripple[0];
    end else begin
      sym   <= code;
    end
  end

endmodule

// File: rtl/fx_pcs_tx_encoder.sv
// fx_pcs_tx_encoder: 100BASE-FX PCS transmit stage (MII nibbles -> 4B/5B).
//   i_clk, i_res        : 25 MHz clock, synchronous active-high reset
//   i_mii_tx_en/txd/er  : MII transmit inputs
//   o_tx_code           : 4B/5B code group, 2 clk after the MII input
//   o_tx_sym            : NRZI (or plain) line word, 3 clk after the MII input
//   o_busy              : high on every slot that carries a stream code (J..R)
//   o_violation         : 1-clk pulse on runt frame or missing inter-packet gap
//
// state   | meaning
// S_IDLE  | sending I; en_d starts a stream with J
// S_SSD_K | sending K (second start delimiter); no en_d here means a runt
// S_DATA  | sending data code groups (H when er_d)
// S_ESD_T | sending T after a runt
// S_ESD_R | sending R; en_d here is dropped and flagged
module fx_pcs_tx_encoder
  import fx_pcs_pkg::*;
#(
  parameter bit   NRZI_EN   = 1'b1,
  parameter logic NRZI_INIT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_mii_tx_en,
  input  logic [3:0] i_mii_txd,
  input  logic       i_mii_tx_er,
  output logic [4:0] o_tx_code,
  output logic [4:0] o_tx_sym,
  output logic       o_busy,
  output logic       o_violation
);

  logic       en_d;
  logic [3:0] txd_d;
  logic       er_d;
  state_t     state;

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      en_d  <= 1'b0;
      txd_d <= 4'h0;
      er_d  <= 1'b0;
    end else begin
      en_d  <= i_mii_tx_en;
      txd_d <= i_mii_txd;
      er_d  <= i_mii_tx_er;
    end
  end

  // o_busy follows the emitted code rather than the next state, so it covers
  // the J slot (leaving idle) and the R slot (returning to idle).
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state       <= S_IDLE;
      o_tx_code   <= CODE_I;
      o_busy      <= 1'b0;
      o_violation <= 1'b0;
    end else begin
      o_violation <= 1'b0;
      o_busy      <= 1'b1;
      case (state)
        S_IDLE: begin
          if (en_d) begin
            o_tx_code <= CODE_J;
            state     <= S_SSD_K;
          end else begin
            o_tx_code <= CODE_I;
            o_busy    <= 1'b0;
          end
        end
        S_SSD_K: begin
          o_tx_code <= CODE_K;
          if (en_d) begin
            state <= S_DATA;
          end else begin
            o_violation <= 1'b1;
            state       <= S_ESD_T;
          end
        end
        S_DATA: begin
          if (en_d) begin
            o_tx_code <= er_d ? CODE_H : enc4b5b(txd_d);
          end else begin
            o_tx_code <= CODE_T;
            state     <= S_ESD_R;
          end
        end
        S_ESD_T: begin
          o_tx_code <= CODE_T;
          state     <= S_ESD_R;
        end
        S_ESD_R: begin
          o_tx_code   <= CODE_R;
          o_violation <= en_d;
          state       <= S_IDLE;
        end
        default: begin
          o_tx_code <= CODE_I;
          o_busy    <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  fx_nrzi_word #(
    .NRZI_EN   (NRZI_EN),
    .NRZI_INIT (NRZI_INIT)
  ) u_nrzi (
    .i_clk (i_clk),
    .i_res (i_res),
    .code  (o_tx_code),
    .sym   (o_tx_sym)
  );

endmodule
